// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM
// states and the select/operation codes driven onto the datapath muxes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_A     = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/mc_imm_decoder.sv
// Immediate-format selector: a pure function of the opcode, independent of
// the FSM state, so the extender is always ready when the FSM needs it.
module mc_imm_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] Op,
  output logic [2:0]      ImmSrc
);

  // Map each opcode to its immediate layout; unknown opcodes use I-format.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    ImmSrc = IMM_I;
    case (Op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      OP_LUI:  ImmSrc = IMM_U;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main controller (Moore FSM) with memory-ready handshake,
// wait-state watchdog and retire pulse.
// Optional macro CTRL_TRAP_ILLEGAL_EN: unknown opcodes halt the core and set
// a sticky illegal_instr flag instead of retiring as a NOP.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W        = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      ALUOp,
  output logic            retire,
  output logic            mem_timeout
`ifdef CTRL_TRAP_ILLEGAL_EN
  ,
  output logic            illegal_instr
`endif
);

  state_t              state, state_next;
  logic [TO_CNT_W-1:0] to_cnt;
  logic                in_wait;
  logic                wd_expire;
  logic                pc_update;
  logic                branch;
  logic                illegal_hit;

  mc_imm_decoder #(.OP_W(OP_W)) u_imm_decoder (
    .Op     (Op),
    .ImmSrc (ImmSrc)
  );

  // Only the three memory-handshake states are watched. The watchdog fires
  // on the cycle whose stall would be the MEM_TIMEOUT-th consecutive one;
  // a ready in that cycle means no stall, so the access simply completes.
  assign in_wait   = (state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);
  assign wd_expire = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                     (to_cnt == TO_CNT_W'(MEM_TIMEOUT - 1));

  assign PCWrite = pc_update | (branch & Zero);

  // State register plus watchdog counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      to_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      state       <= state_next;
      to_cnt      <= (in_wait && !mem_ready && !wd_expire) ?
                     to_cnt + TO_CNT_W'(1) : '0;
      mem_timeout <= mem_timeout | wd_expire;
    end
  end

`ifdef CTRL_TRAP_ILLEGAL_EN
  // Sticky record that an unknown opcode reached DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_instr <= 1'b0;
    else        illegal_instr <= illegal_instr | illegal_hit;
  end
`endif

  // Next-state selection and Moore outputs for the current state.
  always_comb begin
    state_next  = state;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    retire      = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    illegal_hit = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready)      state_next = S_DECODE;
        else if (wd_expire) state_next = S_HALT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default: begin
`ifdef CTRL_TRAP_ILLEGAL_EN
            illegal_hit = 1'b1;
            state_next  = S_HALT;
`else
            retire     = 1'b1;
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        state_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready)      state_next = S_MEMWB;
        else if (wd_expire) state_next = S_HALT;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready)      state_next = S_FETCH;
        else if (wd_expire) state_next = S_HALT;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_A;
        ALUOp      = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUOp      = ALU_SUB;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: an instruction-level model
// (per-opcode step schedule) is compared every cycle, plus literal checks.
module tb_multicycle_ctrl_fsm;

  localparam int MEM_TIMEOUT = 16;
`ifdef CTRL_TRAP_ILLEGAL_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         LU = 7'b0110111, BAD = 7'b1111111;

  logic clk = 1'b0, rst_n = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] Op = LW;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, mem_timeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
`ifdef CTRL_TRAP_ILLEGAL_EN
  logic illegal_instr;
`endif

  multicycle_ctrl_fsm #(.OP_W(7), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .retire(retire),
    .mem_timeout(mem_timeout)
`ifdef CTRL_TRAP_ILLEGAL_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- instruction-level model ----------------
  function automatic int instr_len(input logic [6:0] op);
    case (op)
      LW:                 return 5;
      SW, RT, IT, LU, JL: return 4;
      BQ:                 return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic bit is_wait(input logic [6:0] op, input int step);
    return (step == 0) || (step == 3 && (op == LW || op == SW));
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      SW: return 3'b001;
      BQ: return 3'b010;
      JL: return 3'b011;
      LU: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUOp,retire,mem_timeout}
  function automatic logic [17:0] expect_vec(input logic [6:0] op, input int step,
      input logic rdy, input logic z, input bit halted, input bit to);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ret = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0;
    if (!halted) begin
      if (step == 0) begin
        sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy;
      end else if (step == 1) begin
        sa = 2'b01; sb = 2'b01;
        if (instr_len(op) == 2 && !TRAP) ret = 1;
      end else if (step == 2) begin
        case (op)
          LW, SW: begin sa = 2'b10; sb = 2'b01; end
          RT:     begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
          IT:     begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
          LU:     begin sa = 2'b11; sb = 2'b01; end
          JL:     begin sa = 2'b01; sb = 2'b10; pcw = 1; end
          BQ:     begin sa = 2'b10; aop = 2'b01; pcw = z; ret = 1; end
          default: ;
        endcase
      end else if (step == 3) begin
        if (op == LW)      adr = 1;
        else if (op == SW) begin adr = 1; mw = 1; ret = rdy; end
        else begin rw = 1; ret = 1; end
      end else begin
        rs = 2'b01; rw = 1; ret = 1;
      end
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(op), aop, ret, to};
  endfunction

  int m_step = 0, m_cnt = 0;
  bit m_halt = 0, m_to = 0, m_ill = 0;

  // Model advance: one schedule step per cycle unless stalled on memory.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0; m_cnt <= 0; m_halt <= 0; m_to <= 0; m_ill <= 0;
    end else if (!m_halt) begin
      if (is_wait(Op, m_step) && !mem_ready) begin
        if (MEM_TIMEOUT != 0 && m_cnt + 1 == MEM_TIMEOUT) begin
          m_halt <= 1; m_to <= 1; m_cnt <= 0;
        end else m_cnt <= m_cnt + 1;
      end else begin
        m_cnt <= 0;
        if (TRAP && m_step == 1 && instr_len(Op) == 2) begin
          m_halt <= 1; m_ill <= 1;
        end
        m_step <= (m_step + 1 == instr_len(Op)) ? 0 : m_step + 1;
      end
    end
  end

  // Per-cycle comparison on the falling edge, plus event tallies.
  int c_retire = 0, c_regwrite = 0, c_memwrite = 0, c_pcwrite = 0;
  always @(negedge clk) begin
    check("cycle_outputs",
          {14'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUOp, retire, mem_timeout},
          {14'd0, expect_vec(Op, m_step, mem_ready, Zero, m_halt, m_to)});
`ifdef CTRL_TRAP_ILLEGAL_EN
    check("illegal_instr", {31'd0, illegal_instr}, {31'd0, m_ill});
`endif
    c_retire   += int'(retire);
    c_regwrite += int'(RegWrite);
    c_memwrite += int'(MemWrite);
    c_pcwrite  += int'(PCWrite);
  end

  task automatic tick(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_simple(input logic [6:0] op, input logic z);
    Op = op; Zero = z;
    for (int i = 0; i < instr_len(op); i++) tick(1'b1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
  endtask

  int r0, w0, m0, p0;

  initial begin
    // Reset: FETCH outputs with mem_ready low.
    tick(1'b0);
    tick(1'b0);
    check("reset_alusrcb", {30'd0, ALUSrcB}, 32'd2);
    check("reset_resultsrc", {30'd0, ResultSrc}, 32'd2);
    check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    rst_n = 1'b1;

    // lw, no stalls: 5 cycles, writeback only in the fifth.
    Op = LW; r0 = c_retire; w0 = c_regwrite;
    for (int i = 0; i < 4; i++) tick(1'b1);
    check("lw_wb_regwrite", {31'd0, RegWrite}, 32'd1);
    check("lw_wb_resultsrc", {30'd0, ResultSrc}, 32'd1);
    tick(1'b1);
    check("lw_retire_count", c_retire - r0, 32'd1);
    check("lw_regwrite_count", c_regwrite - w0, 32'd1);

    // beq taken then not taken: PCWrite in fetch plus BEQ when Zero=1.
    Op = BQ; Zero = 1'b1; p0 = c_pcwrite;
    tick(1'b1); tick(1'b1);
    check("beq_aluop", {30'd0, ALUOp}, 32'd1);
    tick(1'b1);
    check("beq_taken_pcwrite", c_pcwrite - p0, 32'd2);
    p0 = c_pcwrite;
    run_simple(BQ, 1'b0);
    check("beq_not_taken_pcwrite", c_pcwrite - p0, 32'd1);

    // Remaining single-pass instruction classes.
    r0 = c_retire;
    run_simple(RT, 1'b0);
    run_simple(IT, 1'b0);
    run_simple(LU, 1'b0);
    run_simple(JL, 1'b0);
    check("alu_group_retires", c_retire - r0, 32'd4);

    // sw with 3 stall cycles in MEMWRITE.
    Op = SW; m0 = c_memwrite; r0 = c_retire;
    tick(1'b1); tick(1'b1); tick(1'b1);
    check("sw_immsrc", {29'd0, ImmSrc}, 32'd1);
    tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1);
    check("sw_memwrite_cycles", c_memwrite - m0, 32'd4);
    check("sw_retire_count", c_retire - r0, 32'd1);
    check("sw_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // lw with MEM_TIMEOUT-1 stalls in MEMREAD: just under the limit.
    Op = LW; r0 = c_retire;
    tick(1'b1); tick(1'b1); tick(1'b1);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick(1'b0);
    tick(1'b1); tick(1'b1);
    check("lw_edge_no_timeout", {31'd0, mem_timeout}, 32'd0);
    check("lw_edge_retire", c_retire - r0, 32'd1);

    // Unknown opcode.
    Op = BAD; r0 = c_retire; w0 = c_regwrite;
    tick(1'b1); tick(1'b1);
    tick(1'b0);
`ifdef CTRL_TRAP_ILLEGAL_EN
    check("illegal_flag", {31'd0, illegal_instr}, 32'd1);
    check("illegal_halt_alusrcb", {30'd0, ALUSrcB}, 32'd0);
    check("illegal_no_retire", c_retire - r0, 32'd0);
`else
    check("illegal_nop_fetch_alusrcb", {30'd0, ALUSrcB}, 32'd2);
    check("illegal_nop_retire", c_retire - r0, 32'd1);
`endif
    check("illegal_no_regwrite", c_regwrite - w0, 32'd0);
    reset_pulse();

    // Reset asserted mid-MEMWRITE.
    Op = SW;
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
    check("pre_reset_memwrite", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort_memwrite", {31'd0, MemWrite}, 32'd0);
    check("reset_abort_alusrcb", {30'd0, ALUSrcB}, 32'd2);
    tick(1'b0);
    rst_n = 1'b1;
    m0 = c_memwrite; w0 = c_regwrite;
    tick(1'b0); tick(1'b0); tick(1'b0);
    check("post_reset_no_memwrite", c_memwrite - m0, 32'd0);
    check("post_reset_no_regwrite", c_regwrite - w0, 32'd0);

    // Watchdog: mem_ready stuck low in FETCH.
    reset_pulse();
    Op = LW;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick(1'b0);
    check("wd_before_limit", {31'd0, mem_timeout}, 32'd0);
    tick(1'b0);
    check("wd_at_limit", {31'd0, mem_timeout}, 32'd1);
    p0 = c_pcwrite; r0 = c_retire;
    for (int i = 0; i < 4; i++) tick(1'b1);
    check("halt_no_pcwrite", c_pcwrite - p0, 32'd0);
    check("halt_no_retire", c_retire - r0, 32'd0);
    check("halt_irwrite", {31'd0, IRWrite}, 32'd0);
    reset_pulse();
    check("wd_cleared_by_reset", {31'd0, mem_timeout}, 32'd0);
    tick(1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
